// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Round-robin arbiter sharing one synchronous SRAM port between two
//            masters, with hold-counter-bounded locked bursts.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int MAX_BURST = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BE_W-1:0]   m0_byte_en,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BE_W-1:0]   m1_byte_en,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [BE_W-1:0]   sram_byte_en,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int                 c_cnt_w = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MAX_BURST);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic               r_last_gnt;
    logic               r_owner_locked;
    logic               r_owner;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic [1:0]         r_rd_pend;

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic               w_lock_hold;
    logic               w_gsel;
    logic               w_next_lock;

    assign w_req = {m1_req, m0_req};

    // The owner keeps the port unless its burst budget is spent while the other master waits.
    assign w_lock_hold = r_owner_locked & w_req[r_owner]
                       & ((r_burst_cnt < c_max) | ~w_req[~r_owner]);

    always_comb begin
        w_gnt = 2'b00;
        if (HRESETn) begin
            if (w_lock_hold) begin
                w_gnt[r_owner] = 1'b1;
            end else begin
                case (w_req)
                    2'b01:   w_gnt = 2'b01;
                    2'b10:   w_gnt = 2'b10;
                    2'b11:   w_gnt = r_last_gnt ? 2'b01 : 2'b10;
                    default: w_gnt = 2'b00;
                endcase
            end
        end
    end

    assign w_gsel      = w_gnt[1];
    assign w_next_lock = w_gsel ? m1_lock : m0_lock;

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];
    assign sram_en = |w_gnt;

    always_comb begin
        sram_wen     = 1'b0;
        sram_addr    = '0;
        sram_byte_en = '0;
        sram_wdata   = '0;
        if (w_gnt[0]) begin
            sram_wen     = m0_wen;
            sram_addr    = m0_addr;
            sram_byte_en = m0_byte_en;
            sram_wdata   = m0_wdata;
        end else if (w_gnt[1]) begin
            sram_wen     = m1_wen;
            sram_addr    = m1_addr;
            sram_byte_en = m1_byte_en;
            sram_wdata   = m1_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_gnt     <= 1'b1;
            r_owner_locked <= 1'b0;
            r_owner        <= 1'b0;
            r_burst_cnt    <= '0;
            r_rd_pend      <= 2'b00;
        end else begin
            r_rd_pend <= w_gnt & ~{m1_wen, m0_wen};
            if (|w_gnt) begin
                r_last_gnt     <= w_gsel;
                r_owner        <= w_gsel;
                r_owner_locked <= w_next_lock;
                if ((w_gsel == r_owner) && r_owner_locked) begin
                    r_burst_cnt <= (r_burst_cnt == c_max) ? r_burst_cnt : r_burst_cnt + c_one;
                end else begin
                    r_burst_cnt <= c_one;
                end
            end else begin
                r_owner_locked <= 1'b0;
                r_burst_cnt    <= '0;
            end
        end
    end

    assign m0_rvalid = r_rd_pend[0];
    assign m1_rvalid = r_rd_pend[1];
    assign m0_rdata  = sram_rdata;
    assign m1_rdata  = sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_port_arbiter
// Purpose  : Directed bench for sram_port_arbiter with a transaction-level
//            reference model and an SRAM macro model.
// Revision : 1.0
// ============================================================================
module tb_sram_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXB = 8;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b0;
    logic          req  [2];
    logic          lock [2];
    logic          wen  [2];
    logic [AW-1:0] addr [2];
    logic [BW-1:0] be   [2];
    logic [DW-1:0] wd   [2];

    logic          gnt0, gnt1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic          sram_en, sram_wen;
    logic [AW-1:0] sram_addr;
    logic [BW-1:0] sram_byte_en;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_BURST(MAXB)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m0_req(req[0]), .m0_lock(lock[0]), .m0_wen(wen[0]), .m0_addr(addr[0]),
        .m0_byte_en(be[0]), .m0_wdata(wd[0]), .m0_gnt(gnt0), .m0_rvalid(rv0), .m0_rdata(rd0),
        .m1_req(req[1]), .m1_lock(lock[1]), .m1_wen(wen[1]), .m1_addr(addr[1]),
        .m1_byte_en(be[1]), .m1_wdata(wd[1]), .m1_gnt(gnt1), .m1_rvalid(rv1), .m1_rdata(rd1),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_byte_en(sram_byte_en), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // SRAM macro: one-cycle read latency, byte-lane writes.
    logic [DW-1:0] emem [0:1023];
    always @(posedge HCLK) begin
        if (sram_en) begin
            if (sram_wen) begin
                for (int b = 0; b < BW; b++)
                    if (sram_byte_en[b]) emem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= emem[sram_addr];
            end
        end
    end

    // Reference model: arbitration rules applied to master-level transactions.
    int            m_last, m_owner, m_burst;
    bit            m_locked;
    bit            m_pend [2];
    logic [DW-1:0] m_exp  [2];
    logic [DW-1:0] mmem   [0:1023];
    int            mg;

    function automatic int pick();
        if (!HRESETn) return -1;
        if (m_locked && req[m_owner] && (m_burst < MAXB || !req[1 - m_owner])) return m_owner;
        if (req[0] && req[1]) return 1 - m_last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    always_comb mg = pick();

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_last <= 1; m_owner <= 0; m_locked <= 0; m_burst <= 0;
            m_pend[0] <= 0; m_pend[1] <= 0;
        end else begin
            if (mg >= 0) begin
                m_last   <= mg;
                m_owner  <= mg;
                m_locked <= lock[mg];
                m_burst  <= (mg == m_owner && m_locked) ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 1;
                if (wen[mg]) mmem[addr[mg]] <= merge(mmem[addr[mg]], wd[mg], be[mg]);
                else         m_exp[mg] <= mmem[addr[mg]];
            end else begin
                m_locked <= 0;
                m_burst  <= 0;
            end
            m_pend[0] <= (mg == 0) && !wen[0];
            m_pend[1] <= (mg == 1) && !wen[1];
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge HCLK) begin
        chk("m0_gnt", gnt0, mg == 0);
        chk("m1_gnt", gnt1, mg == 1);
        chk("sram_en", sram_en, mg >= 0);
        chk("sram_wen", sram_wen, (mg >= 0) ? wen[mg] : 1'b0);
        chk("sram_addr", sram_addr, (mg >= 0) ? addr[mg] : '0);
        chk("sram_byte_en", sram_byte_en, (mg >= 0) ? be[mg] : '0);
        chk("sram_wdata", sram_wdata, (mg >= 0) ? wd[mg] : '0);
        chk("m0_rvalid", rv0, m_pend[0]);
        chk("m1_rvalid", rv1, m_pend[1]);
        if (m_pend[0]) chk("m0_rdata", rd0, m_exp[0]);
        if (m_pend[1]) chk("m1_rdata", rd1, m_exp[1]);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic setm(input int m, input bit r, input bit l, input bit w,
                        input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
        req[m] = r; lock[m] = l; wen[m] = w; addr[m] = a; be[m] = b; wd[m] = d;
    endtask

    task automatic idle();
        setm(0, 0, 0, 0, '0, '0, '0);
        setm(1, 0, 0, 0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt1;
        int bl [12];
        int eb [12];
        eb = '{1, 2, 3, 4, 5, 6, 7, 8, 1, 1, 2, 3};
        for (int i = 0; i < 1024; i++) begin
            emem[i] = '0;
            mmem[i] = '0;
        end
        idle();

        // Reset: a pending request must not be granted.
        req[0] = 1;
        @(negedge HCLK);
        chk("rst_m0_gnt", gnt0, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_m0_rvalid", rv0, 1'b0);
        tick();
        idle();
        HRESETn = 1;
        tick();

        // Single master write then read.
        setm(0, 1, 0, 1, 10'h010, 4'hF, 32'hDEADBEEF);
        @(negedge HCLK);
        chk("s1_wr_gnt", gnt0, 1'b1);
        chk("s1_wr_addr", sram_addr, 10'h010);
        tick();
        setm(0, 1, 0, 0, 10'h010, 4'h0, 32'h0);
        @(negedge HCLK);
        chk("s1_rd_gnt", gnt0, 1'b1);
        tick();
        idle();
        @(negedge HCLK);
        chk("s1_rvalid", rv0, 1'b1);
        chk("s1_rdata", rd0, 32'hDEADBEEF);
        chk("s1_m1_rvalid", rv1, 1'b0);
        tick();

        // Contention from reset, no lock.
        HRESETn = 0;
        tick();
        HRESETn = 1;
        for (int i = 0; i < 6; i++) begin
            setm(0, 1, 0, 0, 10'h010, 4'h0, 32'h0);
            setm(1, 1, 0, 0, 10'h011, 4'h0, 32'h0);
            @(negedge HCLK);
            chk("s2_gnt0", gnt0, (i % 2) == 0);
            chk("s2_gnt1", gnt1, (i % 2) == 1);
            if (i > 0) chk("s2_rv0", rv0, (i % 2) == 1);
            if (i % 2 == 1) chk("s2_rd0", rd0, 32'hDEADBEEF);
            tick();
        end
        idle();
        @(negedge HCLK);
        chk("s2_rv1_last", rv1, 1'b1);
        tick();

        // Locked burst by m1 against continuous m0 traffic.
        cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            setm(1, 1, 1, 1, 10'h100 + AW'(cnt1), 4'hF, 32'hA0000000 + cnt1);
            if (i > 0) setm(0, 1, 0, 0, 10'h010, 4'h0, 32'h0);
            @(negedge HCLK);
            chk("s3_gnt1", gnt1, i != 8);
            chk("s3_gnt0", gnt0, i == 8);
            if (gnt1) cnt1++;
            tick();
            bl[i] = m_burst;
        end
        for (int i = 0; i < 12; i++) chk("s3_burst_model", 64'(bl[i]), 64'(eb[i]));
        idle();
        tick();

        // Lock drop: the waiting master is granted in the same cycle.
        for (int i = 0; i < 4; i++) begin
            setm(0, i < 3, 1, 0, 10'h010, 4'h0, 32'h0);
            setm(1, 1, 0, 0, 10'h101, 4'h0, 32'h0);
            @(negedge HCLK);
            chk("s4_gnt0", gnt0, i < 3);
            chk("s4_gnt1", gnt1, i == 3);
            if (i == 3) chk("s4_sram_en", sram_en, 1'b1);
            tick();
        end
        idle();
        tick();

        // Reset during an m1 read.
        setm(1, 1, 0, 0, 10'h100, 4'h0, 32'h0);
        @(negedge HCLK);
        chk("s5_gnt1_pre", gnt1, 1'b1);
        #1;
        HRESETn = 0;
        #1;
        chk("s5_rst_gnt1", gnt1, 1'b0);
        chk("s5_rst_gnt0", gnt0, 1'b0);
        chk("s5_rst_en", sram_en, 1'b0);
        tick();
        chk("s5_rst_rv1", rv1, 1'b0);
        HRESETn = 1;
        setm(0, 1, 0, 0, 10'h010, 4'h0, 32'h0);
        @(negedge HCLK);
        chk("s5_tie_gnt0", gnt0, 1'b1);
        chk("s5_tie_gnt1", gnt1, 1'b0);
        tick();
        setm(0, 0, 0, 0, '0, '0, '0);
        @(negedge HCLK);
        chk("s5_gnt1_after", gnt1, 1'b1);
        chk("s5_rv0", rv0, 1'b1);
        chk("s5_rd0", rd0, 32'hDEADBEEF);
        tick();
        idle();
        @(negedge HCLK);
        chk("s5_rd1", rd1, 32'hA0000000);
        tick();

        // Byte-lane write over an all-ones word.
        setm(1, 1, 0, 1, 10'h020, 4'hF, 32'hFFFFFFFF);
        tick();
        setm(1, 1, 0, 1, 10'h020, 4'h5, 32'h11223344);
        tick();
        setm(1, 1, 0, 0, 10'h020, 4'h0, 32'h0);
        @(negedge HCLK);
        chk("s6_rd_gnt", gnt1, 1'b1);
        tick();
        idle();
        @(negedge HCLK);
        chk("s6_rvalid", rv1, 1'b1);
        chk("s6_rdata", rd1, 32'hFF22FF44);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares the single synchronous port of an on-chip SRAM macro between the AHB SRAM controller (port 0) and a second master such as a DMA or scrub engine (port 1). It grants at most one access per cycle with round-robin fairness, supports short locked bursts bounded by a hold counter, and routes 1-cycle-latency read data back to the issuing master. It sits between the masters and the SRAM macro, in the slot the SRAM controller normally drives directly.

## Interface
Parameters:
- ADDR_W, 10, SRAM word address width (1024-deep macro)
- DATA_W, 32, data width; must be a multiple of 8
- BE_W, DATA_W/8, byte-enable width (derived)
- MAX_BURST, 8, maximum consecutive grants to one master while the other is waiting; must be at least 1

Ports (X = 0, 1; one set per master):
- HCLK  in  1  clock; all state updates on the rising edge
- HRESETn  in  1  reset; asynchronous, active-low
- mX_req  in  1  access request, valid for the current cycle
- mX_lock  in  1  request to keep the grant in the next cycle
- mX_wen  in  1  1 = write, 0 = read
- mX_addr  in  ADDR_W  word address
- mX_byte_en  in  BE_W  write byte lanes
- mX_wdata  in  DATA_W  write data
- mX_gnt  out  1  access accepted this cycle (combinational)
- mX_rvalid  out  1  read data valid this cycle (registered)
- mX_rdata  out  DATA_W  read data; equals sram_rdata
- sram_en  out  1  macro clock enable / chip enable
- sram_wen  out  1  macro write enable
- sram_addr  out  ADDR_W  macro address
- sram_byte_en  out  BE_W  macro byte enables
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data, valid 1 cycle after a read enable

## Operation
- State registers:
  - last_gnt (1 bit): reset value 1, so that m0 wins the first tie.
  - owner_locked (1 bit): reset value 0.
  - owner (1 bit): reset value 0.
  - burst_cnt (clog2(MAX_BURST+1) bits): reset value 0.
  - rd_pend (2 bits): reset value 0.
- Grant decision, evaluated each cycle in priority order:
  1. Locked owner: if owner_locked=1, mowner_req=1, and (burst_cnt<MAX_BURST or the other master is idle), grant the owner.
  2. Single request: if only one master requests, grant that master.
  3. Both requesting: grant !last_gnt.
  4. No request: no grant, sram_en=0.
- Mux: the granted master's wen, addr, byte_en and wdata drive the sram_* outputs combinationally. sram_en = |gnt. With no grant, sram_wen, sram_addr, sram_byte_en and sram_wdata are all 0.
- On each clock edge with a grant to master g:
  - last_gnt <= g
  - owner <= g
  - owner_locked <= mg_lock
  - burst_cnt <= (g==owner && owner_locked) ? burst_cnt+1 (saturating at MAX_BURST) : 1
- On a clock edge with no grant: owner_locked <= 0 and burst_cnt <= 0.
- Read tracking: rd_pend[X] <= mX_gnt & !mX_wen. Then mX_rvalid = rd_pend[X], and mX_rdata = sram_rdata for both ports.
- Lock release:
  - A locked owner that drops its request loses the lock. The other master is granted in that same cycle.
  - If MAX_BURST is reached while the other master requests, the other master is granted. The counter restarts at 1 for the new owner.
- No write-to-read forwarding. Same-address read-after-write ordering is the macro's behaviour.
- Reset asserted mid-operation clears all state immediately. Any read in flight is discarded: rvalid=0. All gnt outputs are 0 while HRESETn=0.

## Timing
- Arbitration latency: 0 cycles. The grant appears in the same cycle as the request.
- Read latency: 1 cycle from mX_gnt to mX_rvalid.
- Throughput: one access per cycle, and back-to-back accesses may come from different masters.
- A master must hold req, wen, addr, byte_en and wdata stable until it sees gnt. Inputs are only sampled in the gnt cycle.
- Reset values: all outputs 0. sram_* outputs are 0 while no request is present.
- Critical path: req → grant logic → sram_addr mux → macro setup.

## Test plan
- Single master: m0 writes 0xDEADBEEF to address 0x010 with byte_en=0xF, then reads 0x010.
  - Expect m0_gnt in both cycles.
  - Expect m0_rvalid=1 and m0_rdata=0xDEADBEEF one cycle after the read grant.
  - Expect m1_rvalid=0 throughout.
- Contention, no lock: both masters read every cycle for 6 cycles, starting from reset. Expect grants m0,m1,m0,m1,m0,m1, with each rvalid one cycle after the matching grant.
- Locked burst with MAX_BURST=8: m1 requests with lock=1 for 12 cycles while m0 requests continuously.
  - Expect m1 granted for 8 cycles, then m0 for 1 cycle, then m1 again.
  - Expect burst_cnt sequence 1..8, then 1.
- Lock drop: m0 locked for 3 cycles, then deasserts req while m1 is requesting. Expect m1_gnt in that same cycle, with no idle cycle.
- Reset mid-read: m1 read granted, HRESETn pulled low before the next edge.
  - Expect m1_rvalid=0 and all gnt=0 during reset.
  - After release, m0 wins the first tie.
- Byte lanes: m1 writes 0x11223344 with byte_en=0x5 over a location holding 0xFFFFFFFF, then reads it. Expect read data 0xFF22FF44.
